// File: rtl/seg7_pkg.sv
// seg7_pkg: shared state codes, blank patterns and hex glyph table for the seven-segment scan driver
package seg7_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t SHOW = 2'd1;
    localparam state_t GAP  = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] DIG_OFF   = 8'hFF;

    // Active-high gfedcba glyphs for 0..F
    localparam logic [6:0] HEX7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low seven-segment pattern
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = ~HEX7[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 8-digit multiplexed hex display of {value2, value1}; LEADING_ZERO_BLANK_EN blanks leading zeros per 4-digit group
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 50000,
    parameter int GAP_TICKS       = 500
)(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] value1,
    input  logic [15:0] value2,
    input  logic        enable,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  dig_n,
    output logic        frame_done
);

    localparam int MAX_TICKS = TICKS_PER_DIGIT > GAP_TICKS ? TICKS_PER_DIGIT : GAP_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);

    state_t        state;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic [31:0]   snapshot;
    logic          wrap_q;
    logic          show_end, gap_end, step, wrap, start, blank;
    logic [3:0]    nibble;
    logic [6:0]    digit_seg_n;

    assign nibble = snapshot[{idx, 2'b00} +: 4];

    hex_to_seg7 u_hex (
        .nibble (nibble),
        .seg_n  (digit_seg_n)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [15:0] group;
    assign group = idx[2] ? snapshot[31:16] : snapshot[15:0];
    assign blank = idx[1:0] != 2'd0 && (group >> {idx[1:0], 2'b00}) == 16'h0;
`else
    assign blank = 1'b0;
`endif

    // Decode end of dwell, digit step, frame wrap and frame (re)start
    always_comb begin
        show_end = state == SHOW && cnt == CW'(TICKS_PER_DIGIT - 1);
        gap_end  = state == GAP && cnt == CW'(GAP_TICKS - 1);
        step     = gap_end || (show_end && GAP_TICKS == 0);
        wrap     = step && idx == 3'd7;
        start    = enable && (state == IDLE || wrap);
    end

    // Sequence IDLE/SHOW/GAP, advance the digit index and snapshot values at frame start
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            idx      <= 3'd0;
            cnt      <= '0;
            snapshot <= 32'h0;
            wrap_q   <= 1'b0;
        end else begin
            wrap_q <= wrap;
            if (start) begin
                snapshot <= {value2, value1};
                state    <= SHOW;
                idx      <= 3'd0;
                cnt      <= '0;
            end else if (wrap) begin
                state <= IDLE;
                idx   <= 3'd0;
                cnt   <= '0;
            end else if (step) begin
                state <= SHOW;
                idx   <= idx + 3'd1;
                cnt   <= '0;
            end else if (show_end) begin
                state <= GAP;
                cnt   <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Register display drives one cycle behind the sequencer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            dig_n      <= DIG_OFF;
            frame_done <= 1'b0;
        end else begin
            seg_n      <= state == SHOW && !blank ? digit_seg_n : SEG_BLANK;
            dp_n       <= !(state == SHOW && idx == 3'd4);
            dig_n      <= state == SHOW ? ~(8'b1 << idx) : DIG_OFF;
            frame_done <= wrap_q;
        end
    end

endmodule
